// File: rtl/oled_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : oled_pkg                                                 |
// | Description : Shared constants for the SSD1306 128x64 SPI driver:      |
// |               sequencer states, frame/list lengths and the fixed       |
// |               command ROMs (init list and address-window list).        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package oled_pkg;

    localparam int FRAME_BYTES = 1024;
    localparam int INIT_LEN    = 25;
    localparam int ADDR_LEN    = 6;

    // Command ROMs. The first byte sent sits in the most significant slot,
    // so the lists read in transmission order.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    // Horizontal addressing over the full 128x8-page window.
    localparam logic [ADDR_LEN-1:0][7:0] ADDR_ROM = {
        8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
    };

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        RST_WAIT = 3'd1,
        INIT     = 3'd2,
        ADDR     = 3'd3,
        FETCH    = 3'd4,
        DATA     = 3'd5
    } oled_state_t;

    // Byte n of the init list (n counted from the first byte sent).
    function automatic logic [7:0] init_cmd(input logic [4:0] idx);
        return INIT_ROM[5'(INIT_LEN-1) - idx];
    endfunction

    // Byte n of the address-window list.
    function automatic logic [7:0] addr_cmd(input logic [2:0] idx);
        return ADDR_ROM[3'(ADDR_LEN-1) - idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/oled_spi_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : oled_spi_tx                                              |
// | Description : Single-byte SPI mode-0 transmitter, MSB first, with      |
// |               per-byte chip select and latched D/C line.               |
// | Ports       : clk, reset_n     - clock, async active-low reset         |
// |               start            - 1-clk request, honoured when idle     |
// |               tx_byte, tx_dc   - byte and D/C, latched on start        |
// |               sclk, mosi, cs_n - SPI pins                              |
// |               dc               - D/C pin, stable while cs_n is low     |
// |               busy             - transfer in progress                  |
// |               done             - 1-clk pulse as cs_n returns high      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module oled_spi_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       tx_dc,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       dc,
    output logic       busy,
    output logic       done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_bit_cnt;
    logic [6:0]       r_shift;     // bits still to be sent after the one on mosi
    logic             r_sclk;
    logic             r_mosi;
    logic             r_cs_n;
    logic             r_dc;
    logic             r_busy;
    logic             r_done;

    logic             w_phase_end;

    assign w_phase_end = (r_div_cnt == DIV_W'(CLK_DIV - 1));

    // Each bit is CLK_DIV clocks with sclk low (mosi settling) followed by
    // CLK_DIV clocks high; the 8th falling edge ends the byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_dc      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (start) begin
                    r_busy    <= 1'b1;
                    r_cs_n    <= 1'b0;
                    r_sclk    <= 1'b0;
                    r_mosi    <= tx_byte[7];
                    r_shift   <= tx_byte[6:0];
                    r_dc      <= tx_dc;
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                end
            end else if (w_phase_end) begin
                r_div_cnt <= '0;
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                end else begin
                    r_sclk <= 1'b0;
                    if (r_bit_cnt == 3'd7) begin
                        r_busy <= 1'b0;
                        r_cs_n <= 1'b1;
                        r_done <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_mosi    <= r_shift[6];
                        r_shift   <= {r_shift[5:0], 1'b0};
                    end
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign sclk = r_sclk;
    assign mosi = r_mosi;
    assign cs_n = r_cs_n;
    assign dc   = r_dc;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/oled_display_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : oled_display_ctrl                                        |
// | Description : SSD1306 128x64 OLED driver over write-only 4-wire SPI.   |
// |               Pulses the panel reset, sends the init list, then        |
// |               redraws the full 1024-byte frame forever from an         |
// |               external synchronous pixel byte source.                  |
// | Ports       : clk, reset_n        - clock, async active-low reset      |
// |               oled_sclk/mosi/cs_n - SPI pins (mode 0, MSB first)       |
// |               oled_dc             - 0 command, 1 display data          |
// |               oled_res_n          - panel hardware reset               |
// |               pix_addr, pix_data  - frame byte request / 1-clk reply   |
// |               init_done           - sticky, init list fully sent       |
// |               frame_done          - 1-clk pulse after byte 1023        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module oled_display_ctrl
    import oled_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int RST_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       oled_sclk,
    output logic       oled_mosi,
    output logic       oled_cs_n,
    output logic       oled_dc,
    output logic       oled_res_n,
    output logic [9:0] pix_addr,
    input  logic [7:0] pix_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam int TMR_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    oled_state_t      r_state;
    oled_state_t      w_next_state;

    logic [TMR_W-1:0] r_timer;
    logic [4:0]       r_cmd_idx;
    logic             r_issued;      // current byte handed to tx, awaiting done
    logic             r_fetch_wait;  // first FETCH clock spent waiting for pix_data
    logic [7:0]       r_pix_byte;
    logic [9:0]       r_pix_addr;
    logic             r_init_done;
    logic             r_frame_done;

    logic             w_timer_end;
    logic             w_init_last;
    logic             w_addr_last;
    logic             w_pix_last;
    logic             w_tx_start;
    logic [7:0]       w_tx_byte;
    logic             w_tx_dc;
    logic             w_tx_busy;
    logic             w_tx_done;
    logic             w_res_n;

    assign w_timer_end = (r_timer == TMR_W'(RST_CYCLES - 1));
    assign w_init_last = (r_cmd_idx == 5'(INIT_LEN - 1));
    assign w_addr_last = (r_cmd_idx == 5'(ADDR_LEN - 1));
    assign w_pix_last  = (r_pix_addr == 10'(FRAME_BYTES - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RST_HOLD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RST_HOLD: if (w_timer_end) w_next_state = RST_WAIT;
            RST_WAIT: if (w_timer_end) w_next_state = INIT;
            INIT:     if (w_tx_done && w_init_last) w_next_state = ADDR;
            ADDR:     if (w_tx_done && w_addr_last) w_next_state = FETCH;
            FETCH:    if (r_fetch_wait) w_next_state = DATA;
            DATA:     if (w_tx_done) w_next_state = w_pix_last ? ADDR : FETCH;
            default:  w_next_state = RST_HOLD;
        endcase
    end

    // ---------------- output logic ----------------
    // One start per byte: r_issued blocks re-issue until tx reports done.
    always_comb begin
        w_res_n    = 1'b1;
        w_tx_start = 1'b0;
        w_tx_byte  = 8'h00;
        w_tx_dc    = 1'b0;
        case (r_state)
            RST_HOLD: w_res_n = 1'b0;
            INIT: begin
                w_tx_start = !r_issued && !w_tx_busy;
                w_tx_byte  = init_cmd(r_cmd_idx);
            end
            ADDR: begin
                w_tx_start = !r_issued && !w_tx_busy;
                w_tx_byte  = addr_cmd(r_cmd_idx[2:0]);
            end
            DATA: begin
                w_tx_start = !r_issued && !w_tx_busy;
                w_tx_byte  = r_pix_byte;
                w_tx_dc    = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- counters, timer, pixel path ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer      <= '0;
            r_cmd_idx    <= '0;
            r_issued     <= 1'b0;
            r_fetch_wait <= 1'b0;
            r_pix_byte   <= '0;
            r_pix_addr   <= '0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_tx_start) begin
                r_issued <= 1'b1;
            end else if (w_tx_done) begin
                r_issued <= 1'b0;
            end

            case (r_state)
                RST_HOLD, RST_WAIT: begin
                    r_timer <= w_timer_end ? '0 : r_timer + 1'b1;
                end
                INIT: begin
                    if (w_tx_done) begin
                        if (w_init_last) begin
                            r_cmd_idx   <= '0;
                            r_init_done <= 1'b1;
                        end else begin
                            r_cmd_idx <= r_cmd_idx + 5'd1;
                        end
                    end
                end
                ADDR: begin
                    if (w_tx_done) begin
                        r_cmd_idx <= w_addr_last ? 5'd0 : r_cmd_idx + 5'd1;
                    end
                end
                FETCH: begin
                    // pix_addr is already on the bus; the source answers one
                    // clock later, so the second FETCH clock captures it.
                    if (!r_fetch_wait) begin
                        r_fetch_wait <= 1'b1;
                    end else begin
                        r_fetch_wait <= 1'b0;
                        r_pix_byte   <= pix_data;
                    end
                end
                DATA: begin
                    if (w_tx_done) begin
                        if (w_pix_last) begin
                            r_pix_addr   <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_pix_addr <= r_pix_addr + 10'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    oled_spi_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_tx_start),
        .tx_byte (w_tx_byte),
        .tx_dc   (w_tx_dc),
        .sclk    (oled_sclk),
        .mosi    (oled_mosi),
        .cs_n    (oled_cs_n),
        .dc      (oled_dc),
        .busy    (w_tx_busy),
        .done    (w_tx_done)
    );

    assign oled_res_n = w_res_n;
    assign pix_addr   = r_pix_addr;
    assign init_done  = r_init_done;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_oled_display_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_oled_display_ctrl                                     |
// | Description : Scoreboard bench for oled_display_ctrl. Expected SPI     |
// |               bytes are queued up front; an SPI monitor decodes every  |
// |               cs_n window and compares it against the queue head.      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_oled_display_ctrl;

    localparam int CLK_DIV     = 2;
    localparam int RST_CYCLES  = 16;
    localparam int INIT_N      = 25;
    localparam int ADDR_N      = 6;
    localparam int FRAME_N     = 1024;
    localparam int BYTE_TIMING = (16 * CLK_DIV) * 65536 + 8 * 256 + 8 * CLK_DIV;

    typedef struct packed {
        logic       dc;
        logic [7:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       oled_sclk, oled_mosi, oled_cs_n, oled_dc, oled_res_n;
    logic [9:0] pix_addr;
    logic [7:0] pix_data = 8'h00;
    logic       init_done, frame_done;

    logic [7:0] init_tbl [INIT_N] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
                                      8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8,
                                      8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB,
                                      8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] addr_tbl [ADDR_N] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    exp_t exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    // monitor state
    int         cyc = 0;
    int         bytes_seen = 0;
    int         last_rise = 0;
    int         fd_count = 0;
    int         idle_viol = 0;
    logic       in_byte = 1'b0;
    logic       prev_sclk = 1'b0;
    logic [7:0] sh = 8'h00;
    int         nbits = 0;
    int         span = 0;
    int         sclk_hi = 0;
    logic       dc_at_fall = 1'b0;
    logic       dc_bad = 1'b0;

    oled_display_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .oled_sclk  (oled_sclk),
        .oled_mosi  (oled_mosi),
        .oled_cs_n  (oled_cs_n),
        .oled_dc    (oled_dc),
        .oled_res_n (oled_res_n),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous byte source: one clock of latency, byte = address low bits.
    always @(posedge clk) pix_data <= pix_addr[7:0];

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void check_reset(input string tag);
        chk({tag, "_sclk"},       int'(oled_sclk),  0);
        chk({tag, "_mosi"},       int'(oled_mosi),  0);
        chk({tag, "_cs_n"},       int'(oled_cs_n),  1);
        chk({tag, "_dc"},         int'(oled_dc),    0);
        chk({tag, "_res_n"},      int'(oled_res_n), 0);
        chk({tag, "_pix_addr"},   int'(pix_addr),   0);
        chk({tag, "_init_done"},  int'(init_done),  0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endfunction

    function automatic logic pins_idle();
        return (oled_sclk == 1'b0) && (oled_mosi == 1'b0) && (oled_cs_n == 1'b1) &&
               (oled_dc == 1'b0) && (pix_addr == 10'd0) && !init_done && !frame_done;
    endfunction

    task automatic push_init();
        for (int i = 0; i < INIT_N; i++) exp_q.push_back({1'b0, init_tbl[i]});
    endtask

    // ---------------- SPI monitor / scoreboard ----------------
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            in_byte   = 1'b0;
            prev_sclk = 1'b0;
        end else begin
            if (frame_done) begin
                fd_count++;
                chk("frame_done_after_byte1023", bytes_seen, INIT_N + ADDR_N + FRAME_N);
            end
            if (oled_cs_n && oled_sclk) idle_viol++;

            if (!in_byte && !oled_cs_n) begin
                in_byte    = 1'b1;
                nbits      = 0;
                span       = 0;
                sclk_hi    = 0;
                sh         = 8'h00;
                dc_at_fall = oled_dc;
                dc_bad     = 1'b0;
            end
            if (in_byte && !oled_cs_n) begin
                span++;
                if (oled_dc !== dc_at_fall) dc_bad = 1'b1;
                if (oled_sclk) sclk_hi++;
                if (oled_sclk && !prev_sclk) begin
                    sh = {sh[6:0], oled_mosi};
                    nbits++;
                end
            end else if (in_byte && oled_cs_n) begin
                in_byte   = 1'b0;
                last_rise = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_spi_byte[%0d]: got 0x%0h, expected none", bytes_seen, sh);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("spi_byte[%0d]", bytes_seen), int'(sh), int'(e.b));
                    chk($sformatf("spi_dc[%0d]", bytes_seen), int'({dc_bad, dc_at_fall}), int'({1'b0, e.dc}));
                    chk($sformatf("byte_timing[%0d]", bytes_seen),
                        span * 65536 + nbits * 256 + sclk_hi, BYTE_TIMING);
                end
                bytes_seen++;
            end
            prev_sclk = oled_sclk;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int hold_viol;
        int base;

        push_init();
        for (int i = 0; i < ADDR_N; i++)  exp_q.push_back({1'b0, addr_tbl[i]});
        for (int i = 0; i < FRAME_N; i++) exp_q.push_back({1'b1, 8'(i)});
        for (int i = 0; i < ADDR_N; i++)  exp_q.push_back({1'b0, addr_tbl[i]});

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset("por");

        // Panel reset sequencing
        @(negedge clk);
        reset_n   = 1'b1;
        hold_viol = 0;
        n = 0;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (oled_res_n) break;
            if (!pins_idle()) hold_viol++;
        end
        chk("res_n_low_clks", n, RST_CYCLES);
        n = 0;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (!oled_cs_n) break;
            if (!pins_idle() || !oled_res_n) hold_viol++;
        end
        // RST_CYCLES of wait, then one clock from start to cs_n fall
        chk("res_n_high_to_first_cs_fall", n, RST_CYCLES + 1);
        chk("pins_idle_during_panel_reset", hold_viol, 0);

        // Init list
        n = 0;
        while (n < 3000) begin
            @(negedge clk); #1;
            n++;
            if (init_done) break;
        end
        chk("init_done_seen", int'(init_done), 1);
        chk("init_done_one_clk_after_AF", cyc - last_rise, 1);
        chk("init_bytes_before_init_done", bytes_seen, INIT_N);

        // Full frame plus restart of the address list
        n = 0;
        while (n < 60000) begin
            @(negedge clk); #1;
            n++;
            if (bytes_seen >= INIT_N + 2 * ADDR_N + FRAME_N) break;
        end
        chk("frame_bytes_seen", bytes_seen, INIT_N + 2 * ADDR_N + FRAME_N);
        chk("frame_queue_drained", exp_q.size(), 0);
        chk("frame_done_pulses", fd_count, 1);
        chk("init_done_sticky", int'(init_done), 1);

        // Clean restart, then abort the 10th init byte during its 4th bit
        reset_n = 1'b0;
        exp_q.delete();
        push_init();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = bytes_seen;
        n = 0;
        while (n < 3000) begin
            @(negedge clk); #1;
            n++;
            if (bytes_seen == base + 9 && in_byte && nbits == 3 && !oled_sclk) break;
        end
        chk("reached_byte10_bit4", bytes_seen - base, 9);
        reset_n = 1'b0;
        #1 check_reset("mid_byte");
        exp_q.delete();
        push_init();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        base = bytes_seen;
        n = 0;
        while (n < 3000) begin
            @(negedge clk); #1;
            n++;
            if (init_done) break;
        end
        chk("reinit_done_seen", int'(init_done), 1);
        chk("reinit_bytes", bytes_seen - base, INIT_N);
        chk("reinit_queue_drained", exp_q.size(), 0);
        chk("sclk_low_while_cs_high", idle_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
